// File: rtl/aes_loader_pkg.sv
// Shared sizing constants, lane type and FSM encoding for the masked byte-serial state loader.
package aes_loader_pkg;

  localparam int NUM_BYTES = 16;
  localparam int WORD_W    = 8;
  localparam int STATE_W   = NUM_BYTES * WORD_W;
  localparam int LANE_W    = 4;

  typedef logic [LANE_W-1:0] lane_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

  // Byte k occupies [STATE_W-8k : STATE_W-8k-7] in the [STATE_W:1] numbering.
  function automatic int lane_msb(input lane_t lane);
    return STATE_W - WORD_W * int'(lane);
  endfunction

endpackage

// File: rtl/loader_share_buffer.sv
// Per-share state register written one byte lane at a time.
// It sees only its own share byte, so the two share datapaths stay separate.
module loader_share_buffer
  import aes_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  lane_t             lane_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [STATE_W:1]  state_o
);

  logic [STATE_W:1] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (we_i) begin
      buf_d[lane_msb(lane_i) -: WORD_W] = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign state_o = buf_q;

endmodule

// File: rtl/masked_state_loader.sv
// Assembles two 128-bit share states from byte pairs and hands them downstream.
// States: IDLE | one cycle after reset; FILL | accepting bytes; FULL | states presented until consumed.
module masked_state_loader
  import aes_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_share0,
  input  logic [WORD_W-1:0] in_share1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STATE_W:1]  out_state_s0,
  output logic [STATE_W:1]  out_state_s1,
  output logic [3:0]        byte_cnt
);

  logic [1:0] state_q, state_d;
  lane_t      cnt_q, cnt_d;
  logic       accept;
  logic       load;

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_FULL);
  assign accept    = in_valid && in_ready;
  // abort wins over a simultaneous accept, so that byte never reaches a buffer.
  assign load      = accept && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
        if (abort) begin
          cnt_d = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(NUM_BYTES - 1)) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  loader_share_buffer u_buf_s0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (load),
    .lane_i  (cnt_q),
    .data_i  (in_share0),
    .state_o (out_state_s0)
  );

  loader_share_buffer u_buf_s1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (load),
    .lane_i  (cnt_q),
    .data_i  (in_share1),
    .state_o (out_state_s1)
  );

  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_masked_state_loader.sv
// Directed bench for masked_state_loader with hand-computed expected share states.
module tb_masked_state_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_share0 = 8'h00;
  logic [7:0]   in_share1 = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state_s0;
  logic [127:0] out_state_s1;
  logic [3:0]   byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  masked_state_loader dut (
    .clk          (clk),
    .rst          (rst),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_share0    (in_share0),
    .in_share1    (in_share1),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state_s0 (out_state_s0),
    .out_state_s1 (out_state_s1),
    .byte_cnt     (byte_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_share0 = a;
    in_share1 = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Captures every out_valid cycle during the back-to-back run.
  int           cyc = 0;
  int           n_ov = 0;
  logic         mon_en = 1'b0;
  logic [127:0] snap0 [2];
  logic [127:0] snap1 [2];
  int           tv [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (n_ov < 2) begin
        snap0[n_ov] = out_state_s0;
        snap1[n_ov] = out_state_s1;
        tv[n_ov]    = cyc;
      end
      n_ov = n_ov + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;

    // Reset values and the single IDLE cycle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_byte_cnt", 128'(byte_cnt), 128'd0);
    chk("rst_s0", out_state_s0, 128'h0);
    chk("rst_s1", out_state_s1, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1;
    chk("fill_in_ready", 128'(in_ready), 128'd1);

    // Test 1: full state, MSB-first byte placement
    for (int k = 0; k < 16; k++) begin
      push(8'(k), 8'(8'hF0 + k));
      chk("t1_byte_cnt", 128'(byte_cnt), 128'((k + 1) % 16));
      if (k == 14) chk("t1_out_valid_early", 128'(out_valid), 128'd0);
    end
    chk("t1_out_valid", 128'(out_valid), 128'd1);
    chk("t1_in_ready", 128'(in_ready), 128'd0);
    chk("t1_s0", out_state_s0, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_s1", out_state_s1, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

    // Test 2: backpressure holds everything stable
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_in_ready", 128'(in_ready), 128'd0);
      chk("t2_out_valid", 128'(out_valid), 128'd1);
      chk("t2_s0", out_state_s0, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t2_s1", out_state_s1, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    end
    @(posedge clk);
    #1;
    consume();
    chk("t2_in_ready_after", 128'(in_ready), 128'd1);
    chk("t2_out_valid_after", 128'(out_valid), 128'd0);
    chk("t2_no_clear_s0", out_state_s0, 128'h000102030405060708090A0B0C0D0E0F);

    // Test 3: in_valid toggling, accepts on even cycles only
    j = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid  = (i % 2 == 0);
      in_share0 = 8'(8'hA0 + j);
      in_share1 = 8'(8'h50 + j);
      @(posedge clk);
      #1;
      if (i % 2 == 0) j++;
      chk("t3_byte_cnt", 128'(byte_cnt), 128'(j % 16));
    end
    in_valid = 1'b0;
    chk("t3_out_valid", 128'(out_valid), 128'd1);
    chk("t3_s0", out_state_s0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    chk("t3_s1", out_state_s1, 128'h505152535455565758595A5B5C5D5E5F);
    consume();

    // Test 4: abort after 7 bytes drops the 8th and keeps old buffer contents
    for (int k = 0; k < 7; k++) push(8'(8'h11 + k), 8'(8'h91 + k));
    chk("t4_cnt_before", 128'(byte_cnt), 128'd7);
    in_valid  = 1'b1;
    abort     = 1'b1;
    in_share0 = 8'hEE;
    in_share1 = 8'hEE;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t4_cnt_after", 128'(byte_cnt), 128'd0);
    chk("t4_in_ready", 128'(in_ready), 128'd1);
    chk("t4_drop_s0", out_state_s0, 128'h11121314151617A7A8A9AAABACADAEAF);
    chk("t4_drop_s1", out_state_s1, 128'h919293949596975758595A5B5C5D5E5F);
    for (int k = 0; k < 16; k++) push(8'(8'h30 + k), 8'(8'hC0 + k));
    chk("t4_out_valid", 128'(out_valid), 128'd1);
    chk("t4_s0", out_state_s0, 128'h303132333435363738393A3B3C3D3E3F);
    chk("t4_s1", out_state_s1, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t4_full_abort_valid", 128'(out_valid), 128'd1);
    chk("t4_full_abort_ready", 128'(in_ready), 128'd0);
    chk("t4_full_abort_s0", out_state_s0, 128'h303132333435363738393A3B3C3D3E3F);
    consume();

    // Test 5: reset in the middle of a load
    for (int k = 0; k < 9; k++) push(8'(8'h60 + k), 8'(8'h70 + k));
    chk("t5_cnt_before", 128'(byte_cnt), 128'd9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_s0", out_state_s0, 128'h0);
    chk("t5_s1", out_state_s1, 128'h0);
    chk("t5_byte_cnt", 128'(byte_cnt), 128'd0);
    chk("t5_in_ready", 128'(in_ready), 128'd0);
    chk("t5_out_valid", 128'(out_valid), 128'd0);
    chk("t5_fsm_idle", 128'(dut.state_q), 128'd0);
    @(posedge clk);
    #1;
    chk("t5_in_ready_later", 128'(in_ready), 128'd1);

    // Test 6: back-to-back states with out_ready tied high
    mon_en    = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) push(8'(8'h80 + k), 8'(8'h0F - k));
    for (int k = 0; k < 16; k++) push(8'(8'hB0 + k), 8'(8'hD0 + k));
    repeat (3) @(posedge clk);
    #1;
    mon_en    = 1'b0;
    out_ready = 1'b0;
    chk("t6_valid_cycles", 128'(n_ov), 128'd2);
    chk("t6_period", 128'(tv[1] - tv[0]), 128'd17);
    chk("t6_a_s0", snap0[0], 128'h808182838485868788898A8B8C8D8E8F);
    chk("t6_a_s1", snap1[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t6_b_s0", snap0[1], 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    chk("t6_b_s1", snap1[1], 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
